// File: rtl/bpsk_symbol_mapper_if.sv
// rtl/bpsk_symbol_mapper_if.sv - byte handshake bundle feeding the BPSK symbol mapper
interface bpsk_symbol_mapper_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bpsk_symbol_mapper.sv
// rtl/bpsk_symbol_mapper.sv - byte-to-BPSK symbol serializer, one symbol per SYM_PERIOD clocks (option: BPSK_DIFF_ENCODE_EN)
module bpsk_symbol_mapper #(
  parameter int SYM_PERIOD = 5,
  parameter int AMPLITUDE  = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  bpsk_symbol_mapper_if.slave  s,
  output logic [7:0]           symbol_out,
  output logic                 symbol_strobe,
  output logic                 busy,
  output logic                 underrun
);

  localparam int CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_PERIOD - 1);
  localparam logic [7:0] LVL_POS = 8'(AMPLITUDE);
  localparam logic [7:0] LVL_NEG = 8'(-AMPLITUDE);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [CW-1:0] cnt;
  logic [0:0]    state;
  logic          hold_full;
  logic [7:0]    hold_byte;
  logic [7:0]    shift_reg;
  logic [3:0]    bits_left;

  logic tick;
  logic accept;
  logic load;
  logic emit_data;
  logic data_bit;
  logic tx_bit;
  logic underrun_nxt;

  assign tick      = (cnt == CNT_LAST);
  assign s.s_ready = !hold_full;
  assign accept    = s.s_valid && !hold_full;
  // Reload happens only when the shifter is empty; acceptance needs an empty
  // holding register, so the two can never fall in the same cycle.
  assign load      = tick && hold_full && ((state == IDLE) || (bits_left == 4'd0));
  assign busy      = hold_full || (state == STREAM);

  // Decide what the coming tick emits: a fresh byte's MSB, the next shifted bit, or idle
  always_comb begin
    emit_data    = 1'b0;
    data_bit     = 1'b0;
    underrun_nxt = 1'b0;
    if (tick) begin
      if (load) begin
        emit_data = 1'b1;
        data_bit  = hold_byte[7];
      end else if ((state == STREAM) && (bits_left != 4'd0)) begin
        emit_data = 1'b1;
        data_bit  = shift_reg[7];
      end else if (state == STREAM) begin
        underrun_nxt = 1'b1;
      end
    end
  end

`ifdef BPSK_DIFF_ENCODE_EN
  logic prev_tx;

  assign tx_bit = data_bit ^ prev_tx;

  // Differential reference: advances only on data ticks, survives idle gaps
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_tx <= 1'b0;
    end else if (emit_data) begin
      prev_tx <= tx_bit;
    end
  end
`else
  assign tx_bit = data_bit;
`endif

  // Free-running symbol period counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Holding register: filled by the handshake, drained into the shifter on a tick
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_byte <= 8'h00;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_byte <= s.s_data;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Shifter and IDLE/STREAM state; shift_reg[7] is always the next bit to send
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= 8'h00;
      bits_left <= 4'd0;
    end else if (load) begin
      state     <= STREAM;
      shift_reg <= {hold_byte[6:0], 1'b0};
      bits_left <= 4'd7;
    end else if (tick && (state == STREAM)) begin
      if (bits_left != 4'd0) begin
        shift_reg <= shift_reg << 1;
        bits_left <= bits_left - 4'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Registered symbol, strobe and underrun, all updated at the end of the tick cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      symbol_out    <= 8'h00;
      symbol_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      symbol_strobe <= tick;
      underrun      <= underrun_nxt;
      if (tick) begin
        symbol_out <= emit_data ? (tx_bit ? LVL_POS : LVL_NEG) : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// tb/tb_bpsk_symbol_mapper.sv - directed bench for bpsk_symbol_mapper (SYM_PERIOD 5 and 2 instances)
module tb_bpsk_symbol_mapper;

  localparam int P  = 5;
  localparam int P2 = 2;
  localparam logic [7:0] POS = 8'h64;
  localparam logic [7:0] NEG = 8'h9C;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] symbol_out, symbol_out2;
  logic       symbol_strobe, symbol_strobe2;
  logic       busy, busy2;
  logic       underrun, underrun2;

  int checks = 0;
  int errors = 0;

  bpsk_symbol_mapper_if bus ();
  bpsk_symbol_mapper_if bus2 ();

  bpsk_symbol_mapper #(.SYM_PERIOD(P), .AMPLITUDE(100)) dut (
    .clock(clock), .reset(reset), .s(bus.slave),
    .symbol_out(symbol_out), .symbol_strobe(symbol_strobe),
    .busy(busy), .underrun(underrun)
  );

  bpsk_symbol_mapper #(.SYM_PERIOD(P2), .AMPLITUDE(100)) dut2 (
    .clock(clock), .reset(reset), .s(bus2.slave),
    .symbol_out(symbol_out2), .symbol_strobe(symbol_strobe2),
    .busy(busy2), .underrun(underrun2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t vecs[4];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for symbol_strobe", name);
  endtask

  // Reset, check reset values, release and check first tick arrives after P clocks.
  // Returns at the negedge where that first strobe is visible.
  task automatic do_reset();
    int cyc;
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    repeat (3) @(negedge clock);
    chk8("rst_symbol", symbol_out, 8'h00);
    chk1("rst_strobe", symbol_strobe, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_s_ready", bus.s_ready, 1'b1);
    reset = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!symbol_strobe && cyc < 50);
    if (!symbol_strobe) timeout("first_tick");
    else chki("first_tick_delay", cyc, P);
  endtask

  // Feed n bytes (held valid back to back) starting start_delay cycles after a strobe,
  // checking every strobe until the idle symbol that follows the last byte.
  task automatic run_stream(input string name, input int n,
                            input logic [7:0] d0, input logic [7:0] e0,
                            input logic [7:0] d1, input logic [7:0] e1,
                            input int start_delay);
    logic [7:0] exp_q[$];
    logic [7:0] eb;
    logic       will_accept;
    logic       had_data = 1'b0;
    logic       done = 1'b0;
    int cyc = 0;
    int last = 0;
    int fed = 0;
    int bitidx = 0;
    if (start_delay == 0) begin
      bus.s_valid = 1'b1;
      bus.s_data = d0;
    end
    while (!done && cyc < 2000) begin
      will_accept = bus.s_valid && bus.s_ready;
      @(negedge clock);
      cyc++;
      if (symbol_strobe) begin
        chki({name, "_period"}, cyc - last, P);
        last = cyc;
        if (exp_q.size() > 0) begin
          chk8({name, "_symbol"}, symbol_out, exp_q.pop_front());
          chk1({name, "_underrun"}, underrun, 1'b0);
          chk1({name, "_busy"}, busy, 1'b1);
          if (bitidx == 0) chk1({name, "_ready_after_transfer"}, bus.s_ready, 1'b1);
          bitidx = (bitidx + 1) % 8;
          had_data = 1'b1;
        end else begin
          chk8({name, "_idle_symbol"}, symbol_out, 8'h00);
          chk1({name, "_idle_underrun"}, underrun, had_data);
          if (had_data && fed == n) done = 1'b1;
          had_data = 1'b0;
        end
      end
      if (will_accept) begin
        eb = (fed == 0) ? e0 : e1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(eb[i] ? POS : NEG);
        chk1({name, "_ready_low_when_held"}, bus.s_ready, 1'b0);
        fed++;
        if (fed < n) bus.s_data = d1;
        else bus.s_valid = 1'b0;
      end
      if (fed == 0 && !bus.s_valid && cyc == start_delay) begin
        bus.s_valid = 1'b1;
        bus.s_data = d0;
      end
    end
    if (!done) timeout({name, "_end"});
    @(negedge clock);
    chk1({name, "_underrun_pulse_end"}, underrun, 1'b0);
    chk1({name, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic next_strobe(input string name);
    int cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!symbol_strobe && cyc < 100);
    if (!symbol_strobe) timeout(name);
  endtask

  logic [7:0] e_ff, e_00, e_80, e_f0, e_01;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus2.s_valid = 1'b0;
    bus2.s_data = 8'h00;

`ifdef BPSK_DIFF_ENCODE_EN
    vecs[0] = '{8'hA5, 8'hC6};
    vecs[1] = '{8'h80, 8'hFF};
    vecs[2] = '{8'hFF, 8'hAA};
    vecs[3] = '{8'h01, 8'h01};
    e_ff = 8'hAA; e_00 = 8'h00; e_80 = 8'hFF; e_f0 = 8'hA0; e_01 = 8'h01;
`else
    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h80, 8'h80};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h01, 8'h01};
    e_ff = 8'hFF; e_00 = 8'h00; e_80 = 8'h80; e_f0 = 8'hF0; e_01 = 8'h01;
`endif

    // Single bytes, each from a fresh reset
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_stream("single", 1, vecs[i].data, vecs[i].exp_bits, 8'h00, 8'h00, 0);
    end

    // Back-to-back bytes with no idle symbol between them
    do_reset();
    run_stream("b2b", 2, 8'hFF, e_ff, 8'h00, e_00, 0);

    // Byte presented in the tick cycle while idle: first strobe stays idle
    do_reset();
    run_stream("tick_accept", 1, 8'h80, e_80, 8'h00, 8'h00, P - 1);

    // Reset in the middle of a byte
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data = 8'hF0;
    @(negedge clock);
    bus.s_valid = 1'b0;
    for (int k = 7; k >= 5; k--) begin
      next_strobe("mid_reset_sym");
      chk8("mid_reset_sym", symbol_out, e_f0[k] ? POS : NEG);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk8("mid_reset_symbol", symbol_out, 8'h00);
    chk1("mid_reset_strobe", symbol_strobe, 1'b0);
    chk1("mid_reset_underrun", underrun, 1'b0);
    chk1("mid_reset_busy", busy, 1'b0);
    chk1("mid_reset_s_ready", bus.s_ready, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_strobe("post_reset_idle");
      chk8("post_reset_idle_symbol", symbol_out, 8'h00);
      chk1("post_reset_idle_underrun", underrun, 1'b0);
      chk1("post_reset_idle_busy", busy, 1'b0);
    end

    // SYM_PERIOD = 2 instance, byte 8'h01
    begin
      int cyc = 0;
      int last = 0;
      do begin
        @(negedge clock);
        cyc++;
      end while (!symbol_strobe2 && cyc < 20);
      if (!symbol_strobe2) timeout("p2_sync");
      bus2.s_valid = 1'b1;
      bus2.s_data = 8'h01;
      @(negedge clock);
      bus2.s_valid = 1'b0;
      cyc = 1;
      last = 0;
      for (int k = 8; k >= 0; k--) begin
        while (!symbol_strobe2 && cyc < 60) begin
          @(negedge clock);
          cyc++;
        end
        if (!symbol_strobe2) begin
          timeout("p2_symbol");
          break;
        end
        if (k < 8) chki("p2_period", cyc - last, P2);
        last = cyc;
        if (k > 0) begin
          chk8("p2_symbol", symbol_out2, e_01[k-1] ? POS : NEG);
        end else begin
          chk8("p2_idle_symbol", symbol_out2, 8'h00);
          chk1("p2_underrun", underrun2, 1'b1);
        end
        @(negedge clock);
        cyc++;
      end
      chk1("p2_busy_end", busy2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpsk_symbol_mapper.md
# bpsk_symbol_mapper

Upstream feeder for the upsampler in the BPSK modulator chain. Accepts payload bytes over a valid/ready handshake, serializes them MSB-first, maps each bit to a signed 8-bit BPSK level (±AMPLITUDE) and holds each symbol for exactly SYM_PERIOD clocks. The output period matches the upsampler's N+1 cycle count. A two-stage byte buffer (holding register plus shift register) sustains gapless streaming.

## Interface
- SYM_PERIOD, 5: clocks per symbol; legal range 2..256. Set to the upsampler's N+1.
- AMPLITUDE, 100: magnitude of the mapped level; legal range 1..127.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- s_data  in  8  payload byte, MSB transmitted first
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept a byte this cycle
- symbol_out  out  8  signed two's-complement BPSK level; drives the upsampler data_in
- symbol_strobe  out  1  one-cycle pulse in the cycle symbol_out takes a new value
- busy  out  1  a byte is in the shifter or holding register, or a data symbol is on symbol_out
- underrun  out  1  one-cycle pulse when streaming breaks

## Operation
- Tick counter: width $clog2(SYM_PERIOD). Runs freely 0..SYM_PERIOD-1 and wraps. A tick occurs when count == SYM_PERIOD-1.
- Holding register (hold_full flag):
  - s_ready = !hold_full, decoded from the registered flag only.
  - A byte is accepted when s_valid && s_ready. The accepted byte sets hold_full.
- Shifter: 8-bit shift register plus a 4-bit remaining-bit count (bits_left, 0..8).
- FSM states: IDLE, STREAM.
  - IDLE: on a tick with hold_full, load the holding byte into the shifter, clear hold_full, emit bit 7, set bits_left=7, go to STREAM. On a tick without hold_full, emit idle level 0.
  - STREAM: on a tick with bits_left>0, emit the next bit and decrement bits_left.
  - STREAM, bits_left==0, hold_full: reload from the holding register and emit its bit 7. No gap is inserted.
  - STREAM, bits_left==0, !hold_full: emit 0, pulse underrun, go to IDLE.
- Mapping: bit 1 → +AMPLITUDE; bit 0 → −AMPLITUDE (8-bit two's complement). Idle → 8'h00.
- symbol_strobe pulses on every tick, including idle ticks.
- Acceptance and a holding→shifter transfer never coincide: acceptance requires !hold_full and transfer requires hold_full. A byte accepted in the tick cycle itself is not eligible until the next tick.
- Reset mid-operation discards the shifter and holding contents and returns all state to reset values. No partial byte is completed.

## Timing
- Reset values:
  - symbol_out = 0, symbol_strobe = 0, underrun = 0, busy = 0, s_ready = 1.
  - Tick counter = 0, FSM = IDLE, hold_full = 0, bits_left = 0.
- symbol_out, symbol_strobe and underrun are registered. They update on the clock edge that ends the tick cycle and hold for SYM_PERIOD clocks.
- First tick after reset release: SYM_PERIOD clocks after reset deasserts.
- Latency: a byte accepted in cycle t with t not a tick cycle appears (bit 7) at the first tick after t.
- Sustained throughput: 1 byte per 8·SYM_PERIOD clocks. s_ready reasserts the cycle after each holding→shifter transfer.
- underrun asserts in the same cycle as the idle symbol_strobe. It is never asserted on idle ticks that follow idle ticks.

## Configuration
- BPSK_DIFF_ENCODE_EN defined: differential encoding before mapping.
  - tx_bit = data_bit XOR prev_tx.
  - prev_tx updates only on data ticks. It holds across idle gaps and is cleared to 0 by reset only.
- BPSK_DIFF_ENCODE_EN undefined: tx_bit = data_bit, and no prev_tx register exists.

## Test plan
- Single byte, SYM_PERIOD=5, AMPLITUDE=100, byte 8'hA5 (macro off):
  - symbol_out sequence +100, −100, +100, −100, −100, +100, −100, +100, i.e. 8'h64/8'h9C, each held 5 clocks.
  - Then one idle 0 with an underrun pulse; busy then drops.
- Back-to-back 8'hFF then 8'h00, s_valid held high:
  - 8 symbols of +100 then 8 of −100 with no idle symbol between.
  - s_ready low while hold_full, high one cycle after each transfer.
- Byte presented in the exact tick cycle while IDLE: not emitted on that tick. It is emitted on the following tick, 5 clocks later.
- Reset asserted after 3 symbols of 8'hF0:
  - Next cycle all outputs at reset values.
  - After release, only 0 symbols appear until a new byte is accepted.
- BPSK_DIFF_ENCODE_EN defined, byte 8'h80 from reset: tx bits 1,1,1,1,1,1,1,1, giving 8 symbols of +100.
- SYM_PERIOD=2 boundary: symbol_strobe every other clock. 8'h01 yields seven −100 then one +100, each held 2 clocks.
